// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply/divide unit with HI/LO result registers.
// One shift-add (mult) or restoring shift-subtract (div) step per cycle, 32 steps per op.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state, state_nxt;

    logic [4:0]  cnt;
    logic [63:0] acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd;     // multiplicand or divisor magnitude
    logic [31:0] a_q;
    logic        is_div, neg_q, neg_r, dz;

    logic        accept, last, sgn, sa, sb;
    logic [31:0] ma, mb;
    logic [32:0] add_sum, r_sh;
    logic [31:0] sub;
    logic [63:0] acc_step;
    logic [31:0] hi_fin, lo_fin;

    assign accept = start && (state == S_IDLE) && (mdop >= OP_MULT) && (mdop <= OP_DIVU);
    assign last   = (state == S_RUN) && (cnt == 5'd31);

    always_comb begin
        sgn = (mdop == OP_MULT) || (mdop == OP_DIV);
        sa  = sgn & a[31];
        sb  = sgn & b[31];
        ma  = sa ? 32'd0 - a : a;
        mb  = sb ? 32'd0 - b : b;
    end

    always_comb begin
        add_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        r_sh    = {acc[63:32], acc[31]};
        sub     = r_sh[31:0] - opnd;
        if (is_div)
            acc_step = (r_sh >= {1'b0, opnd}) ? {sub, acc[30:0], 1'b1}
                                              : {r_sh[31:0], acc[30:0], 1'b0};
        else
            acc_step = {add_sum, acc[31:1]};
    end

    // Sign restoration applied to the final step's magnitudes at commit.
    always_comb begin
        hi_fin = acc_step[63:32];
        lo_fin = acc_step[31:0];
        if (!is_div) begin
            if (neg_q) {hi_fin, lo_fin} = 64'd0 - acc_step;
        end else if (dz) begin
            hi_fin = a_q;
            lo_fin = 32'hFFFF_FFFF;
        end else begin
            if (neg_q) lo_fin = 32'd0 - acc_step[31:0];
            if (neg_r) hi_fin = 32'd0 - acc_step[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_RUN;
            S_RUN:  if (last)   state_nxt = S_IDLE;
            default:            state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_q    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                is_div <= (mdop == OP_DIV) || (mdop == OP_DIVU);
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                dz     <= (b == 32'd0);
                a_q    <= a;
                cnt    <= '0;
                if ((mdop == OP_DIV) || (mdop == OP_DIVU)) begin
                    opnd <= mb;
                    acc  <= {32'd0, ma};
                end else begin
                    opnd <= ma;
                    acc  <= {32'd0, mb};
                end
            end else if (state == S_RUN) begin
                acc <= acc_step;
                cnt <= cnt + 5'd1;
                if (last) begin
                    hi   <= hi_fin;
                    lo   <= lo_fin;
                    done <= 1'b1;
                end
            end else if (start && mdop == OP_MTHI) begin
                hi <= a;
            end else if (start && mdop == OP_MTLO) begin
                lo <= a;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table plus hand-written corner sequences,
// with a scoreboard queue of expected hi/lo popped on each done pulse.
module tb_muldiv_unit;
    localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011, DIVU = 3'b100;
    localparam logic [2:0] MTHI = 3'b101, MTLO = 3'b110;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  mdop;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .mdop(mdop), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    typedef struct { logic [2:0] op; logic [31:0] a, b, ehi, elo; } vec_t;
    typedef struct { logic [31:0] hi, lo; } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[13];
    int          total = 0, bad = 0;
    logic [31:0] prev_hi, prev_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [2:0] op, input logic [31:0] aa, bb, ehi, elo);
        exp_t e;
        prev_hi = hi;
        prev_lo = lo;
        start = 1'b1; mdop = op; a = aa; b = bb;
        tick();
        start = 1'b0; mdop = 3'b000; a = $urandom; b = $urandom;
        e.hi = ehi; e.lo = elo;
        sb_q.push_back(e);
        check("busy_after_accept", busy, 1);
        check("done_one_cycle", done, 0);
    endtask

    task automatic wait_done(input int inj_k, input logic [2:0] iop, input logic [31:0] ia, ib);
        int   k = 0, nb = 0;
        exp_t e;
        while (!done && k < 100) begin
            if (busy) nb++;
            if (k == 16) begin
                check("hold_hi", hi, prev_hi);
                check("hold_lo", lo, prev_lo);
            end
            if (k == inj_k) begin
                start = 1'b1; mdop = iop; a = ia; b = ib;
            end
            tick();
            start = 1'b0;
            a = $urandom; b = $urandom;
            k++;
        end
        check("latency", k, 32);
        check("busy_cycles", nb, 32);
        check("busy_low_at_done", busy, 0);
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: got done want no done");
        end else begin
            e = sb_q.pop_front();
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
        end
    endtask

    initial begin
        int ndone;
        vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
        vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[7]  = '{DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[8]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988};
        vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
        vecs[12] = '{MULTU, 32'd0,        32'h9ABCDEF0, 32'h00000000, 32'h00000000};

        reset = 1'b1; start = 1'b0; mdop = 3'b000; a = '0; b = '0;
        tick(); tick();
        check("rst_hi", hi, 0); check("rst_lo", lo, 0);
        check("rst_busy", busy, 0); check("rst_done", done, 0);
        reset = 1'b0;

        // mthi then mtlo on consecutive cycles
        start = 1'b1; mdop = MTHI; a = 32'h12345678;
        tick();
        check("mthi_hi", hi, 32'h12345678); check("mthi_busy", busy, 0); check("mthi_done", done, 0);
        mdop = MTLO; a = 32'h9ABCDEF0;
        tick();
        start = 1'b0;
        check("mtlo_lo", lo, 32'h9ABCDEF0); check("mtlo_hi", hi, 32'h12345678);
        check("mtlo_busy", busy, 0); check("mtlo_done", done, 0);

        // mdop 000 / 111 ignored
        start = 1'b1; mdop = 3'b000; a = 32'hDEADBEEF; b = 32'd3;
        tick();
        mdop = 3'b111;
        tick();
        start = 1'b0;
        check("nop_busy", busy, 0); check("nop_hi", hi, 32'h12345678); check("nop_lo", lo, 32'h9ABCDEF0);

        // table vectors, issued back-to-back in each done cycle
        foreach (vecs[i]) begin
            go(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);
            wait_done(-1, 3'b000, '0, '0);
        end

        // start while busy ignored: divu and mthi injected mid-operation
        go(MULT, 32'd3, 32'd4, 32'd0, 32'd12);
        wait_done(10, DIVU, 32'd9, 32'd3);
        tick();
        check("inject_no_restart", busy, 0);
        go(MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
        wait_done(5, MTHI, 32'hDEAD0000, 32'd0);

        // reset mid-operation aborts with no done
        start = 1'b1; mdop = DIV; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_hi", hi, 0); check("abort_lo", lo, 0);
        check("abort_busy", busy, 0); check("abort_done", done, 0);
        ndone = 0;
        repeat (40) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        go(MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
        wait_done(-1, 3'b000, '0, '0);

        // reset wins over start at the same edge
        reset = 1'b1; start = 1'b1; mdop = MTHI; a = 32'h55555555;
        tick();
        check("rst_prio_hi", hi, 0);
        mdop = MULT; a = 32'd3; b = 32'd3;
        tick();
        reset = 1'b0; start = 1'b0;
        check("rst_prio_busy", busy, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 No parameters; operand width is fixed at 32 bits and iteration count at 32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled each rising edge.
REQ-005 mdop  input  3  000 none, 001 mult (signed), 010 multu, 011 div (signed), 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-006 a  input  32  operand A (multiplicand / dividend / mthi-mtlo data).
REQ-007 b  input  32  operand B (multiplier / divisor).
REQ-008 busy  output  1  iterative operation in progress.
REQ-009 done  output  1  one-cycle pulse on result commit.
REQ-010 hi  output  32  HI register (product high word / remainder).
REQ-011 lo  output  32  LO register (product low word / quotient).

Function
REQ-012 Accept: start=1, busy=0, mdop in {001..100} at edge N -> latch a, b, mdop; busy=1 from after edge N.
REQ-013 Iteration: one shift-add (mult) or shift-subtract restoring step (div) per cycle; exactly 32 steps.
REQ-014 Commit: hi/lo written at edge N+32; busy falls at the same edge; done=1 for the cycle after edge N+32 only.
REQ-015 hi/lo hold previous values throughout busy; no partial results visible.
REQ-016 Signed ops: operands converted to magnitude before iteration; sign fixed at commit.
REQ-017 mult/multu: {hi,lo} = full 64-bit product, two's complement for mult.
REQ-018 div/divu: lo = quotient truncated toward zero; hi = remainder, sign equal to dividend sign.
REQ-019 Divide by zero (b=0): hi = a, lo = 32'hFFFFFFFF, normal 32-cycle latency, no error flag.
REQ-020 Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-021 mthi/mtlo: start=1, busy=0 -> hi (or lo) = a at that edge; busy stays 0; done stays 0.
REQ-022 Any start while busy=1 is ignored: no latch, no hi/lo write, no restart.
REQ-023 start with mdop 000/111 is ignored.
REQ-024 Back-to-back: a start in the cycle busy is 0 after commit (done=1 cycle) is accepted normally.
REQ-025 Operands changing during busy have no effect on the result.

Reset
REQ-026 reset=1 at any edge: hi=0, lo=0, busy=0, done=0, iteration counter cleared.
REQ-027 Reset mid-operation aborts it; no commit, no done pulse follows.
REQ-028 reset has priority over start at the same edge.

Verification
REQ-029 mult a=0xFFFFFFFD(-3), b=5 -> after 32 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse once.
REQ-030 multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE; busy high exactly 32 cycles.
REQ-031 div a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 -> hi=7, lo=0xFFFFFFFF.
REQ-032 mthi a=0x12345678 then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated next edge each, busy never set.
REQ-033 Start mult 3*4, assert start with divu 9/3 at cycle 10 -> second ignored; hi=0, lo=12.
REQ-034 Start div 100/7, reset at cycle 15 -> hi=lo=0, busy=0, no done; new multu 6*7 afterward -> lo=42.
